// File: rtl/ex_pkg.sv
// Shared encodings for the EX ALU issue slice: ALU operations, RV32I opcode/funct3
// constants and the micro-op decoder used at EX-register load.
package ex_pkg;

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SLL = 3'b001,
        ALU_AND = 3'b111
    } aluop_e;

    typedef enum logic [1:0] {
        BR_NONE = 2'd0,
        BR_EQ   = 2'd1,
        BR_NE   = 2'd2
    } br_e;

    localparam logic [6:0] OPC_R  = 7'b0110011;
    localparam logic [6:0] OPC_I  = 7'b0010011;
    localparam logic [6:0] OPC_BR = 7'b1100011;

    localparam logic [2:0] F3_ADD = 3'b000;
    localparam logic [2:0] F3_SLL = 3'b001;
    localparam logic [2:0] F3_AND = 3'b111;
    localparam logic [2:0] F3_BEQ = 3'b000;
    localparam logic [2:0] F3_BNE = 3'b001;

    typedef struct packed {
        aluop_e aluop;
        br_e    br;
        logic   we;
        logic   illegal;
        logic   neg_b;
        logic   use_imm;
    } dec_t;

    // Anything not explicitly recognised stays illegal and never writes back.
    function automatic dec_t decode(input logic [6:0] opcode,
                                    input logic [2:0] funct3,
                                    input logic       funct7b5,
                                    input logic [6:0] imm_hi,
                                    input logic [4:0] rd);
        dec_t d;
        d.aluop   = ALU_ADD;
        d.br      = BR_NONE;
        d.we      = 1'b0;
        d.illegal = 1'b1;
        d.neg_b   = 1'b0;
        d.use_imm = 1'b0;
        case (opcode)
            OPC_R: begin
                case (funct3)
                    F3_ADD: begin
                        d.illegal = 1'b0;
                        d.neg_b   = funct7b5;
                    end
                    F3_SLL: if (!funct7b5) begin
                        d.illegal = 1'b0;
                        d.aluop   = ALU_SLL;
                    end
                    F3_AND: if (!funct7b5) begin
                        d.illegal = 1'b0;
                        d.aluop   = ALU_AND;
                    end
                    default: ;
                endcase
            end
            OPC_I: begin
                d.use_imm = 1'b1;
                case (funct3)
                    F3_ADD: d.illegal = 1'b0;
                    F3_SLL: if (imm_hi == 7'd0) begin
                        d.illegal = 1'b0;
                        d.aluop   = ALU_SLL;
                    end
                    F3_AND: begin
                        d.illegal = 1'b0;
                        d.aluop   = ALU_AND;
                    end
                    default: ;
                endcase
            end
            OPC_BR: begin
                case (funct3)
                    F3_BEQ: begin
                        d.illegal = 1'b0;
                        d.neg_b   = 1'b1;
                        d.br      = BR_EQ;
                    end
                    F3_BNE: begin
                        d.illegal = 1'b0;
                        d.neg_b   = 1'b1;
                        d.br      = BR_NE;
                    end
                    default: ;
                endcase
            end
            default: ;
        endcase
        d.we = !d.illegal && (d.br == BR_NONE) && (rd != 5'd0);
        return d;
    endfunction

endpackage

// File: rtl/ex_alu_issue_alu32.sv
// 32-bit ALU for the EX stage: add (subtract arrives pre-negated), shift-left, and.
module alu32
    import ex_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  aluop_e      aluop,
    output logic [31:0] d,
    output logic        cout,
    output logic        v,
    output logic        z
);

    logic [32:0] sum;

    always_comb begin
        sum  = {1'b0, a} + {1'b0, b};
        d    = 32'd0;
        cout = 1'b0;
        v    = 1'b0;
        case (aluop)
            ALU_ADD: begin
                d    = sum[31:0];
                cout = sum[32];
                v    = (a[31] == b[31]) && (sum[31] != a[31]);
            end
            ALU_SLL: d = a << b[4:0];
            ALU_AND: d = a & b;
            default: d = 32'd0;
        endcase
    end

    assign z = (d == 32'd0);

endmodule

// File: rtl/ex_alu_issue.sv
// Two-stage ALU issue slice: EX register holds forwarded operands and decoded op,
// OUT register holds the registered ALU result and flags under valid/ready flow control.
module ex_alu_issue
    import ex_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [6:0]  in_opcode,
    input  logic [2:0]  in_funct3,
    input  logic        in_funct7b5,
    input  logic [4:0]  in_rs1_idx,
    input  logic [4:0]  in_rs2_idx,
    input  logic [4:0]  in_rd,
    input  logic [31:0] in_rs1_val,
    input  logic [31:0] in_rs2_val,
    input  logic [31:0] in_imm,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_result,
    output logic [4:0]  out_rd,
    output logic        out_we,
    output logic        out_taken,
    output logic        out_carry,
    output logic        out_illegal
);

    logic        ex_valid_q, ex_valid_d;
    aluop_e      ex_aluop_q, ex_aluop_d;
    br_e         ex_br_q, ex_br_d;
    logic        ex_we_q, ex_we_d;
    logic        ex_illegal_q, ex_illegal_d;
    logic [31:0] ex_a_q, ex_a_d;
    logic [31:0] ex_b_q, ex_b_d;
    logic [4:0]  ex_rd_q, ex_rd_d;

    logic        out_valid_q, out_valid_d;
    logic [31:0] out_result_q, out_result_d;
    logic [4:0]  out_rd_q, out_rd_d;
    logic        out_we_q, out_we_d;
    logic        out_taken_q, out_taken_d;
    logic        out_carry_q, out_carry_d;
    logic        out_illegal_q, out_illegal_d;

    logic [31:0] alu_d;
    logic        alu_cout;
    logic        alu_z;
    logic        alu_v_unused;

    logic        out_advance;
    dec_t        dec;
    logic [31:0] rs1_fwd;
    logic [31:0] rs2_fwd;

    alu32 u_alu (
        .a     (ex_a_q),
        .b     (ex_b_q),
        .aluop (ex_aluop_q),
        .d     (alu_d),
        .cout  (alu_cout),
        .v     (alu_v_unused),
        .z     (alu_z)
    );

    assign out_advance = !out_valid_q || out_ready;
    assign in_ready    = !ex_valid_q || out_advance;

    // Youngest producer wins: the op now in EX beats the older one waiting in OUT.
    always_comb begin
        rs1_fwd = in_rs1_val;
        rs2_fwd = in_rs2_val;
        if (in_rs1_idx != 5'd0) begin
            if (ex_valid_q && ex_we_q && ex_rd_q == in_rs1_idx) begin
                rs1_fwd = alu_d;
            end else if (out_valid_q && out_we_q && out_rd_q == in_rs1_idx) begin
                rs1_fwd = out_result_q;
            end
        end
        if (in_rs2_idx != 5'd0) begin
            if (ex_valid_q && ex_we_q && ex_rd_q == in_rs2_idx) begin
                rs2_fwd = alu_d;
            end else if (out_valid_q && out_we_q && out_rd_q == in_rs2_idx) begin
                rs2_fwd = out_result_q;
            end
        end
    end

    always_comb begin
        dec          = decode(in_opcode, in_funct3, in_funct7b5, in_imm[11:5], in_rd);
        ex_valid_d   = ex_valid_q;
        ex_aluop_d   = ex_aluop_q;
        ex_br_d      = ex_br_q;
        ex_we_d      = ex_we_q;
        ex_illegal_d = ex_illegal_q;
        ex_a_d       = ex_a_q;
        ex_b_d       = ex_b_q;
        ex_rd_d      = ex_rd_q;
        if (in_ready) begin
            ex_valid_d = in_valid;
            if (in_valid) begin
                ex_aluop_d   = dec.aluop;
                ex_br_d      = dec.br;
                ex_we_d      = dec.we;
                ex_illegal_d = dec.illegal;
                ex_a_d       = rs1_fwd;
                ex_rd_d      = in_rd;
                if (dec.neg_b) begin
                    ex_b_d = ~rs2_fwd + 32'd1;
                end else if (dec.use_imm) begin
                    ex_b_d = in_imm;
                end else begin
                    ex_b_d = rs2_fwd;
                end
            end
        end
    end

    always_comb begin
        out_valid_d   = out_valid_q;
        out_result_d  = out_result_q;
        out_rd_d      = out_rd_q;
        out_we_d      = out_we_q;
        out_taken_d   = out_taken_q;
        out_carry_d   = out_carry_q;
        out_illegal_d = out_illegal_q;
        if (out_advance) begin
            out_valid_d = ex_valid_q;
            if (ex_valid_q) begin
                out_result_d  = ex_illegal_q ? 32'd0 : alu_d;
                out_rd_d      = ex_rd_q;
                out_we_d      = ex_we_q;
                out_taken_d   = (ex_br_q == BR_EQ && alu_z) || (ex_br_q == BR_NE && !alu_z);
                out_carry_d   = !ex_illegal_q && (ex_aluop_q == ALU_ADD) && alu_cout;
                out_illegal_d = ex_illegal_q;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ex_valid_q    <= 1'b0;
            ex_aluop_q    <= ALU_ADD;
            ex_br_q       <= BR_NONE;
            ex_we_q       <= 1'b0;
            ex_illegal_q  <= 1'b0;
            ex_a_q        <= 32'd0;
            ex_b_q        <= 32'd0;
            ex_rd_q       <= 5'd0;
            out_valid_q   <= 1'b0;
            out_result_q  <= 32'd0;
            out_rd_q      <= 5'd0;
            out_we_q      <= 1'b0;
            out_taken_q   <= 1'b0;
            out_carry_q   <= 1'b0;
            out_illegal_q <= 1'b0;
        end else begin
            ex_valid_q    <= ex_valid_d;
            ex_aluop_q    <= ex_aluop_d;
            ex_br_q       <= ex_br_d;
            ex_we_q       <= ex_we_d;
            ex_illegal_q  <= ex_illegal_d;
            ex_a_q        <= ex_a_d;
            ex_b_q        <= ex_b_d;
            ex_rd_q       <= ex_rd_d;
            out_valid_q   <= out_valid_d;
            out_result_q  <= out_result_d;
            out_rd_q      <= out_rd_d;
            out_we_q      <= out_we_d;
            out_taken_q   <= out_taken_d;
            out_carry_q   <= out_carry_d;
            out_illegal_q <= out_illegal_d;
        end
    end

    assign out_valid   = out_valid_q;
    assign out_result  = out_result_q;
    assign out_rd      = out_rd_q;
    assign out_we      = out_we_q;
    assign out_taken   = out_taken_q;
    assign out_carry   = out_carry_q;
    assign out_illegal = out_illegal_q;

endmodule

// File: tb/tb_ex_alu_issue.sv
// Bench for ex_alu_issue: architectural register model plus in-order scoreboard,
// checked every cycle, with literal expectations on directed micro-op sequences.
module tb_ex_alu_issue;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [6:0]  in_opcode;
    logic [2:0]  in_funct3;
    logic        in_funct7b5;
    logic [4:0]  in_rs1_idx;
    logic [4:0]  in_rs2_idx;
    logic [4:0]  in_rd;
    logic [31:0] in_rs1_val;
    logic [31:0] in_rs2_val;
    logic [31:0] in_imm;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic [4:0]  out_rd;
    logic        out_we;
    logic        out_taken;
    logic        out_carry;
    logic        out_illegal;

    ex_alu_issue dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_opcode   (in_opcode),
        .in_funct3   (in_funct3),
        .in_funct7b5 (in_funct7b5),
        .in_rs1_idx  (in_rs1_idx),
        .in_rs2_idx  (in_rs2_idx),
        .in_rd       (in_rd),
        .in_rs1_val  (in_rs1_val),
        .in_rs2_val  (in_rs2_val),
        .in_imm      (in_imm),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_result  (out_result),
        .out_rd      (out_rd),
        .out_we      (out_we),
        .out_taken   (out_taken),
        .out_carry   (out_carry),
        .out_illegal (out_illegal)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] res;
        logic [4:0]  rd;
        logic        we;
        logic        taken;
        logic        carry;
        logic        illegal;
        int          acc_edge;
    } exp_t;

    typedef struct {
        logic [31:0] res;
        logic [4:0]  rd;
        logic        we;
        logic        taken;
        logic        carry;
        logic        illegal;
    } obs_t;

    exp_t        sb[$];
    obs_t        ret_log[$];
    logic [31:0] arch [32];
    logic [31:0] committed [32];
    int          cyc = 0;
    int          n_vec = 0;
    int          n_bad = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Program-order semantics straight from the ISA: registers read from arch state.
    function automatic exp_t modelOp(input logic [6:0] opc, input logic [2:0] f3, input logic f7b5,
                                     input logic [4:0] rs1, input logic [4:0] rs2,
                                     input logic [4:0] rd, input logic [31:0] imm);
        exp_t        e;
        logic [31:0] a;
        logic [31:0] bv;
        logic        br;
        a         = arch[rs1];
        bv        = arch[rs2];
        br        = 1'b0;
        e.res     = 32'd0;
        e.rd      = rd;
        e.we      = 1'b0;
        e.taken   = 1'b0;
        e.carry   = 1'b0;
        e.illegal = 1'b1;
        e.acc_edge = 0;
        if (opc == 7'b0110011) begin
            if (f3 == 3'd0) begin
                e.illegal = 1'b0;
                if (!f7b5) begin
                    e.res   = a + bv;
                    e.carry = ({1'b0, a} + {1'b0, bv}) > 33'h0FFFFFFFF;
                end else begin
                    e.res   = a - bv;
                    e.carry = (bv != 0) && (a >= bv);
                end
            end else if (f3 == 3'd1 && !f7b5) begin
                e.illegal = 1'b0;
                e.res     = a << bv[4:0];
            end else if (f3 == 3'd7 && !f7b5) begin
                e.illegal = 1'b0;
                e.res     = a & bv;
            end
        end else if (opc == 7'b0010011) begin
            if (f3 == 3'd0) begin
                e.illegal = 1'b0;
                e.res     = a + imm;
                e.carry   = ({1'b0, a} + {1'b0, imm}) > 33'h0FFFFFFFF;
            end else if (f3 == 3'd1 && imm[11:5] == 7'd0) begin
                e.illegal = 1'b0;
                e.res     = a << imm[4:0];
            end else if (f3 == 3'd7) begin
                e.illegal = 1'b0;
                e.res     = a & imm;
            end
        end else if (opc == 7'b1100011 && (f3 == 3'd0 || f3 == 3'd1)) begin
            e.illegal = 1'b0;
            br        = 1'b1;
            e.res     = a - bv;
            e.carry   = (bv != 0) && (a >= bv);
            e.taken   = (f3 == 3'd0) ? (a == bv) : (a != bv);
        end
        e.we = !e.illegal && !br && (rd != 5'd0);
        return e;
    endfunction

    // Per-cycle compare: flow-control outputs every cycle, payload on every retirement.
    always @(negedge clk) begin
        exp_t e;
        obs_t o;
        logic exp_ov;
        checkOutput("in_ready", 32'(in_ready), 32'((sb.size() < 2) || out_ready));
        exp_ov = (sb.size() > 0) ? (sb[0].acc_edge + 1 <= cyc) : 1'b0;
        checkOutput("out_valid", 32'(out_valid), 32'(exp_ov));
        if (!reset) begin
            if (out_valid && out_ready && sb.size() > 0) begin
                e = sb.pop_front();
                checkOutput("sb.result", out_result, e.res);
                checkOutput("sb.rd", 32'(out_rd), 32'(e.rd));
                checkOutput("sb.we", 32'(out_we), 32'(e.we));
                checkOutput("sb.taken", 32'(out_taken), 32'(e.taken));
                checkOutput("sb.carry", 32'(out_carry), 32'(e.carry));
                checkOutput("sb.illegal", 32'(out_illegal), 32'(e.illegal));
                if (e.we) committed[e.rd] = e.res;
                o.res = out_result; o.rd = out_rd; o.we = out_we;
                o.taken = out_taken; o.carry = out_carry; o.illegal = out_illegal;
                ret_log.push_back(o);
            end
            if (in_valid && in_ready) begin
                e = modelOp(in_opcode, in_funct3, in_funct7b5, in_rs1_idx, in_rs2_idx, in_rd, in_imm);
                e.acc_edge = cyc + 1;
                sb.push_back(e);
                if (e.we) arch[e.rd] = e.res;
            end
        end
    end

    // Called just after a rising edge; returns just after the edge that accepted the op.
    task automatic applyStimulus(input logic [6:0] opc, input logic [2:0] f3, input logic f7b5,
                                 input logic [4:0] rs1, input logic [4:0] rs2,
                                 input logic [4:0] rd, input logic [31:0] imm);
        bit done = 0;
        int budget = 0;
        in_valid    = 1'b1;
        in_opcode   = opc;
        in_funct3   = f3;
        in_funct7b5 = f7b5;
        in_rs1_idx  = rs1;
        in_rs2_idx  = rs2;
        in_rd       = rd;
        in_imm      = imm;
        while (!done) begin
            in_rs1_val = committed[rs1];
            in_rs2_val = committed[rs2];
            @(negedge clk);
            done = in_ready;
            @(posedge clk);
            #1;
            budget++;
            if (!done && budget > 50) begin
                n_vec++;
                n_bad++;
                $display("[TB] FAIL accept_timeout: rd %0d not accepted, expected acceptance within 50 cycles", rd);
                done = 1;
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic addi(input logic [4:0] rd, input logic [4:0] rs1, input logic [31:0] imm);
        applyStimulus(7'b0010011, 3'd0, imm[10], rs1, 5'd0, rd, imm);
    endtask

    task automatic rop(input logic [2:0] f3, input logic f7b5, input logic [4:0] rd,
                       input logic [4:0] rs1, input logic [4:0] rs2);
        applyStimulus(7'b0110011, f3, f7b5, rs1, rs2, rd, 32'd0);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expectRetire(input string name, input logic [31:0] r, input logic [4:0] rd,
                                input logic we, input logic taken, input logic carry, input logic illegal);
        int   b = 0;
        obs_t o;
        while (ret_log.size() == 0 && b < 30) begin
            @(posedge clk);
            #1;
            b++;
        end
        if (ret_log.size() == 0) begin
            n_vec++;
            n_bad++;
            $display("[TB] FAIL %s: got no retirement, expected result 0x%08h", name, r);
        end else begin
            o = ret_log.pop_front();
            checkOutput({name, ".result"}, o.res, r);
            checkOutput({name, ".rd"}, 32'(o.rd), 32'(rd));
            checkOutput({name, ".we"}, 32'(o.we), 32'(we));
            checkOutput({name, ".taken"}, 32'(o.taken), 32'(taken));
            checkOutput({name, ".carry"}, 32'(o.carry), 32'(carry));
            checkOutput({name, ".illegal"}, 32'(o.illegal), 32'(illegal));
        end
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation still running, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [15:0] pat;
        int          drain;
        reset = 1'b1;
        in_valid = 1'b0; in_opcode = 7'd0; in_funct3 = 3'd0; in_funct7b5 = 1'b0;
        in_rs1_idx = 5'd0; in_rs2_idx = 5'd0; in_rd = 5'd0;
        in_rs1_val = 32'd0; in_rs2_val = 32'd0; in_imm = 32'd0;
        out_ready = 1'b1;
        for (int i = 0; i < 32; i++) begin
            arch[i] = 32'd0;
            committed[i] = 32'd0;
        end
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("rst_out_result", out_result, 32'd0);
        checkOutput("rst_out_rd", 32'(out_rd), 32'd0);
        checkOutput("rst_out_flags", 32'({out_we, out_taken, out_carry, out_illegal}), 32'd0);
        reset = 1'b0;
        #1;
        checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
        idle(1);

        // ADD x3 = 5 + 7 and its two-edge latency
        addi(5'd1, 5'd0, 32'd5);
        addi(5'd2, 5'd0, 32'd7);
        idle(3);
        expectRetire("addi_x1", 32'd5, 5'd1, 1, 0, 0, 0);
        expectRetire("addi_x2", 32'd7, 5'd2, 1, 0, 0, 0);
        rop(3'd0, 1'b0, 5'd3, 5'd1, 5'd2);
        @(negedge clk);
        checkOutput("lat_edge_n", 32'(out_valid), 32'd0);
        @(negedge clk);
        checkOutput("lat_edge_n1", 32'(out_valid), 32'd1);
        @(posedge clk);
        #1;
        expectRetire("add_x3", 32'd12, 5'd3, 1, 0, 0, 0);

        // SUB, BEQ, BNE with operands forwarded from EX/OUT
        addi(5'd7, 5'd0, 32'd3);
        addi(5'd8, 5'd0, 32'd5);
        rop(3'd0, 1'b1, 5'd4, 5'd7, 5'd8);
        addi(5'd9, 5'd0, 32'd9);
        applyStimulus(7'b1100011, 3'd0, 1'b0, 5'd9, 5'd9, 5'd12, 32'd0);
        applyStimulus(7'b1100011, 3'd1, 1'b0, 5'd7, 5'd8, 5'd0, 32'd0);
        idle(4);
        expectRetire("addi_x7", 32'd3, 5'd7, 1, 0, 0, 0);
        expectRetire("addi_x8", 32'd5, 5'd8, 1, 0, 0, 0);
        expectRetire("sub_x4", 32'hFFFFFFFE, 5'd4, 1, 0, 0, 0);
        expectRetire("addi_x9", 32'd9, 5'd9, 1, 0, 0, 0);
        expectRetire("beq_eq", 32'd0, 5'd12, 0, 1, 1, 0);
        expectRetire("bne_ne", 32'hFFFFFFFE, 5'd0, 0, 1, 0, 0);

        // Back-to-back dependencies, carry out, AND and shifts
        addi(5'd5, 5'd0, 32'd1);
        rop(3'd1, 1'b0, 5'd6, 5'd5, 5'd5);
        addi(5'd11, 5'd0, 32'hFFFFFFFF);
        addi(5'd12, 5'd11, 32'd1);
        applyStimulus(7'b0010011, 3'd7, 1'b0, 5'd11, 5'd0, 5'd13, 32'h000000F0);
        applyStimulus(7'b0010011, 3'd1, 1'b0, 5'd5, 5'd0, 5'd14, 32'd4);
        applyStimulus(7'b0010011, 3'd1, 1'b1, 5'd5, 5'd0, 5'd26, 32'h00000404);
        rop(3'd7, 1'b0, 5'd15, 5'd11, 5'd13);
        idle(4);
        expectRetire("addi_x5", 32'd1, 5'd5, 1, 0, 0, 0);
        expectRetire("sll_fwd", 32'd2, 5'd6, 1, 0, 0, 0);
        expectRetire("addi_m1", 32'hFFFFFFFF, 5'd11, 1, 0, 0, 0);
        expectRetire("addi_wrap", 32'd0, 5'd12, 1, 0, 1, 0);
        expectRetire("andi", 32'h000000F0, 5'd13, 1, 0, 0, 0);
        expectRetire("slli", 32'd16, 5'd14, 1, 0, 0, 0);
        expectRetire("slli_bad", 32'd0, 5'd26, 0, 0, 0, 1);
        expectRetire("and_r", 32'h000000F0, 5'd15, 1, 0, 0, 0);

        // Illegal encodings and writes to x0
        applyStimulus(7'b0000011, 3'd2, 1'b0, 5'd1, 5'd2, 5'd16, 32'd0);
        rop(3'd1, 1'b1, 5'd17, 5'd1, 5'd2);
        rop(3'd0, 1'b0, 5'd0, 5'd1, 5'd2);
        rop(3'd0, 1'b0, 5'd16, 5'd0, 5'd1);
        idle(4);
        expectRetire("load_illegal", 32'd0, 5'd16, 0, 0, 0, 1);
        expectRetire("sll_f7_illegal", 32'd0, 5'd17, 0, 0, 0, 1);
        expectRetire("add_x0", 32'd12, 5'd0, 0, 0, 0, 0);
        expectRetire("x0_not_fwd", 32'd5, 5'd16, 1, 0, 0, 0);

        // Downstream stall for three cycles with three ops offered
        out_ready = 1'b0;
        fork
            begin
                addi(5'd17, 5'd0, 32'd1);
                addi(5'd18, 5'd17, 32'd1);
                addi(5'd19, 5'd18, 32'd1);
            end
            begin
                @(posedge clk);
                @(posedge clk);
                @(negedge clk);
                checkOutput("stall_in_ready", 32'(in_ready), 32'd0);
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        idle(4);
        expectRetire("stall_1", 32'd1, 5'd17, 1, 0, 0, 0);
        expectRetire("stall_2", 32'd2, 5'd18, 1, 0, 0, 0);
        expectRetire("stall_3", 32'd3, 5'd19, 1, 0, 0, 0);

        // Dependent chain under an irregular out_ready pattern
        pat = 16'b1011_0010_1100_1101;
        fork
            begin
                for (int i = 0; i < 6; i++) begin
                    addi(5'd20, 5'd20, 32'(i * 3));
                    rop(3'd0, 1'b0, 5'd21, 5'd21, 5'd20);
                end
            end
            begin
                for (int k = 0; k < 16; k++) begin
                    out_ready = pat[k];
                    @(posedge clk);
                    #1;
                end
                out_ready = 1'b1;
            end
        join
        idle(6);
        ret_log.delete();
        rop(3'd0, 1'b0, 5'd22, 5'd20, 5'd0);
        idle(3);
        expectRetire("chain_sum", 32'd45, 5'd22, 1, 0, 0, 0);

        // Reset with both stages occupied
        out_ready = 1'b0;
        addi(5'd23, 5'd0, 32'd7);
        addi(5'd24, 5'd0, 32'd8);
        reset = 1'b1;
        sb.delete();
        ret_log.delete();
        for (int i = 0; i < 32; i++) arch[i] = committed[i];
        #1;
        checkOutput("rst_mid_out_valid", 32'(out_valid), 32'd0);
        checkOutput("rst_mid_in_ready", 32'(in_ready), 32'd1);
        idle(2);
        reset = 1'b0;
        out_ready = 1'b1;
        idle(5);
        checkOutput("rst_no_output", 32'(ret_log.size()), 32'd0);
        addi(5'd25, 5'd23, 32'd1);
        idle(3);
        expectRetire("post_rst", 32'd1, 5'd25, 1, 0, 0, 0);

        drain = 0;
        while (sb.size() > 0 && drain < 20) begin
            idle(1);
            drain++;
        end
        if (sb.size() > 0) begin
            n_vec++;
            n_bad++;
            $display("[TB] FAIL drain: %0d ops outstanding, expected 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/ex_alu_issue.md
EX_ALU_ISSUE -- requirements
Module: ex_alu_issue

Interface
REQ-001 SHALL have clk  input  1  rising-edge clock for all state.
REQ-002 SHALL have reset  input  1  asynchronous, active-high reset (one clock; reset asynchronous and active-high).
REQ-003 SHALL have in_valid  input  1  upstream micro-op valid.
REQ-004 SHALL have in_ready  output  1  block can accept a micro-op this cycle.
REQ-005 SHALL have in_opcode  input  7  RV32I opcode (0110011 R, 0010011 I-ALU, 1100011 branch).
REQ-006 SHALL have in_funct3  input  3  RV32I funct3.
REQ-007 SHALL have in_funct7b5  input  1  instr bit 30.
REQ-008 SHALL have in_rs1_idx, in_rs2_idx, in_rd  input  5 each  register indices.
REQ-009 SHALL have in_rs1_val, in_rs2_val, in_imm  input  32 each  register-file operands and sign-extended immediate.
REQ-010 SHALL have out_valid  output  1  result valid; out_ready  input  1  downstream accepts.
REQ-011 SHALL have out_result  output  32, out_rd  output  5, out_we  output  1, out_taken  output  1, out_carry  output  1, out_illegal  output  1.

Function
REQ-012 SHALL be two stages: EX register (latched operands, decoded ALUop) then OUT register (registered ALU result/flags).
REQ-013 SHALL transfer in on in_valid&&in_ready; transfer out on out_valid&&out_ready.
REQ-014 SHALL have latency 2: micro-op accepted at edge N appears with out_valid high after edge N+1, given out_ready high.
REQ-015 SHALL stall when out_valid && !out_ready: OUT and EX hold; in_ready = !ex_valid || (!out_valid || out_ready).
REQ-016 SHALL sustain one op per cycle when out_ready stays high.
REQ-017 SHALL decode ALUop 3-bit: ADD 000 (ADD, ADDI, SUB, BEQ, BNE), SLL 001 (SLL, SLLI), AND 111 (AND, ANDI).
REQ-018 SHALL form SUB/BEQ/BNE as ADD with b = (~rs2)+1 computed at EX-register load, modulo 2^32.
REQ-019 SHALL use b = in_imm for I-ALU, SLLI shift amount = imm[4:0]; imm[11:5] nonzero for SLLI is illegal.
REQ-020 SHALL set out_taken = Z for BEQ, !Z for BNE, 0 otherwise; branches set out_we=0.
REQ-021 SHALL flag out_illegal=1, out_we=0, out_result=0 for any other opcode/funct3/funct7b5 combination; op still flows with latency 2.
REQ-022 SHALL set out_we=0 when rd==0; out_carry = ALU Cout for ADD-class, 0 otherwise.
REQ-023 SHALL forward to rs1/rs2 at accept: EX-stage ALU result if ex_valid&&ex_we&&ex_rd==idx, else OUT result if out_valid&&out_we&&out_rd==idx, else in_*_val; index 0 never forwarded.
REQ-024 SHALL apply forwarding before SUB negation.

Reset
REQ-025 SHALL on reset clear ex_valid, out_valid and drive out_result=0, out_rd=0, out_we=0, out_taken=0, out_carry=0, out_illegal=0; in_ready=1 after release.
REQ-026 SHALL discard in-flight ops when reset asserts mid-operation; none reappear after release.

Structure
REQ-027 SHALL place ALUop encodings, opcode constants and funct3 constants in shared package ex_pkg.
REQ-028 SHALL instantiate exactly one sub-module, alu32 (a, b, ALUop -> d, Cout, V, Z), fed by the EX register.

Verification
REQ-029 ADD x3=5+7, out_ready=1 -> out_result=12, out_rd=3, out_we=1, out_valid two cycles after accept.
REQ-030 SUB x4 = 3-5 -> out_result=0xFFFFFFFE, out_carry=0; BEQ 9,9 -> out_taken=1, out_we=0.
REQ-031 back-to-back ADDI x5=x0+1 then SLL x6=x5<<x5 -> second result 2 via EX forwarding.
REQ-032 out_ready low 3 cycles with 3 ops offered -> in_ready low after 2 held ops, no loss/duplication, order kept.
REQ-033 opcode 0000011 -> out_illegal=1, out_we=0, out_result=0; rd=0 ADD -> out_we=0, no forwarding of x0.
REQ-034 reset asserted with both stages full -> out_valid=0 immediately, no output after release.
